// File: rtl/zb_param_fifo.sv
// Parametrised synchronous FIFO with standard or first-word-fall-through read,
// occupancy count, registered threshold flags and sticky overflow/underflow flags.
module zb_param_fifo #(
    parameter int DATA_WIDTH   = 4,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2,
    parameter bit FWFT         = 1'b0,
    parameter int CW           = $clog2(DEPTH + 1)
) (
    input  logic                  inClock,
    input  logic                  inReset,
    input  logic                  inWriteEnable,
    input  logic [DATA_WIDTH-1:0] inData,
    input  logic                  inReadEnable,
    input  logic                  inClearFlags,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outValid,
    output logic                  outFull,
    output logic                  outEmpty,
    output logic                  outAlmostFull,
    output logic                  outAlmostEmpty,
    output logic [CW-1:0]         outCount,
    output logic                  outOverflow,
    output logic                  outUnderflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_COUNT  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_COUNT = CW'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wrPtr_r;
    logic [PW-1:0]         rdPtr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         countNext_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  almostFull_r;
    logic                  almostEmpty_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  readAccept_s;
    logic                  writeAccept_s;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? {PW{1'b0}} : ptr + PW'(1);
    endfunction

    // Accept decisions and next occupancy; a full FIFO takes a write only alongside a pop.
    always_comb begin
        readAccept_s  = inReadEnable & ~empty_r;
        writeAccept_s = inWriteEnable & (~full_r | readAccept_s);
        case ({writeAccept_s, readAccept_s})
            2'b10:   countNext_s = count_r + CW'(1);
            2'b01:   countNext_s = count_r - CW'(1);
            default: countNext_s = count_r;
        endcase
    end

    // Pointers, count, status flags and sticky error flags; a new error beats a clear.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            wrPtr_r       <= {PW{1'b0}};
            rdPtr_r       <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
            full_r        <= 1'b0;
            empty_r       <= 1'b1;
            almostFull_r  <= 1'b0;
            almostEmpty_r <= 1'b1;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            if (writeAccept_s) begin
                wrPtr_r <= nextPtr(wrPtr_r);
            end
            if (readAccept_s) begin
                rdPtr_r <= nextPtr(rdPtr_r);
            end
            count_r       <= countNext_s;
            full_r        <= (countNext_s == FULL_COUNT);
            empty_r       <= (countNext_s == {CW{1'b0}});
            almostFull_r  <= (countNext_s >= AFULL_COUNT);
            almostEmpty_r <= (countNext_s <= AEMPTY_COUNT);
            overflow_r    <= (inWriteEnable & ~writeAccept_s) | (overflow_r & ~inClearFlags);
            underflow_r   <= (inReadEnable & empty_r) | (underflow_r & ~inClearFlags);
        end
    end

    // Storage array; contents are not cleared by reset, only made unreachable.
    always_ff @(posedge inClock) begin
        if (!inReset && writeAccept_s) begin
            mem_r[wrPtr_r] <= inData;
        end
    end

    generate
        if (FWFT) begin : gFwft
            // Head word is presented directly from storage; blanked while empty.
            assign outData  = empty_r ? {DATA_WIDTH{1'b0}} : mem_r[rdPtr_r];
            assign outValid = ~empty_r;
        end else begin : gStd
            logic [DATA_WIDTH-1:0] readData_r;
            logic                  readValid_r;

            // Registered read port: data loads on a pop, valid pulses for one cycle.
            always_ff @(posedge inClock) begin
                if (inReset) begin
                    readData_r  <= {DATA_WIDTH{1'b0}};
                    readValid_r <= 1'b0;
                end else begin
                    readValid_r <= readAccept_s;
                    if (readAccept_s) begin
                        readData_r <= mem_r[rdPtr_r];
                    end
                end
            end

            assign outData  = readData_r;
            assign outValid = readValid_r;
        end
    endgenerate

    assign outFull        = full_r;
    assign outEmpty       = empty_r;
    assign outAlmostFull  = almostFull_r;
    assign outAlmostEmpty = almostEmpty_r;
    assign outCount       = count_r;
    assign outOverflow    = overflow_r;
    assign outUnderflow   = underflow_r;

endmodule

// File: doc/zb_param_fifo.md
# zb_param_fifo

Parametrised synchronous FIFO replacing the fixed-geometry input FIFO (4-bit symbols into the coder) and output FIFO (1-bit decoded data out of the CDR) in the Zigbee transceiver top level. Width, depth, almost-full/almost-empty thresholds and read mode (standard or first-word-fall-through) are set at elaboration. The block also provides an occupancy count and sticky overflow/underflow flags, which the test-access mux can expose for stand-alone checking.

## Interface
- DATA_WIDTH, 4: payload width in bits, ≥1 (4 for the input FIFO, 1 for the output FIFO).
- DEPTH, 16: number of entries, ≥2; need not be a power of two.
- AFULL_LEVEL, DEPTH-2: outAlmostFull asserts when count ≥ AFULL_LEVEL.
- AEMPTY_LEVEL, 2: outAlmostEmpty asserts when count ≤ AEMPTY_LEVEL.
- FWFT, 0: 0 = standard read (data one cycle after the read); 1 = first-word-fall-through.
- CW, $clog2(DEPTH+1): width of the count port (derived; do not override).

Ports:
- inClock  in  1  single clock; all logic on the rising edge.
- inReset  in  1  synchronous, active-high reset.
- inWriteEnable  in  1  write request.
- inData  in  DATA_WIDTH  write data.
- inReadEnable  in  1  read request (pop).
- inClearFlags  in  1  clears the sticky error flags.
- outData  out  DATA_WIDTH  read data.
- outValid  out  1  outData is valid (see Operation).
- outFull / outEmpty  out  1  count == DEPTH / count == 0.
- outAlmostFull / outAlmostEmpty  out  1  threshold flags.
- outCount  out  CW  current occupancy, 0..DEPTH.
- outOverflow / outUnderflow  out  1  sticky error flags.

## Operation
- Storage is a DEPTH-entry register array with write pointer wp and read pointer rp. Each pointer wraps from DEPTH-1 to 0 with explicit compare, not modulo 2^n.
- Write accept: wa = inWriteEnable & (!outFull | ra). A write to a full FIFO is accepted only if a read is accepted in the same cycle.
- Read accept: ra = inReadEnable & !outEmpty. A write in the same cycle to an empty FIFO never satisfies that read.
- Count update: count += wa − ra. Simultaneous wa and ra leave count unchanged and advance both pointers.
- Overflow: set when inWriteEnable & !wa. The data is discarded and no state changes.
- Underflow: set when inReadEnable & outEmpty. No pointer move, and outData is unchanged.
- Sticky flags: inClearFlags clears them. If inClearFlags coincides with a new error event, the event wins and the flag stays 1.
- Standard mode (FWFT=0):
  - outData is registered and loaded with mem[rp] on ra.
  - outValid is a 1-cycle pulse in the cycle after ra.
  - outData holds its last value otherwise.
- FWFT mode (FWFT=1):
  - outData = mem[rp] and outValid = !outEmpty.
  - ra pops the head; the next entry is presented the following cycle.
- All status flags are registered or derived from the registered count; there are no combinational paths from inputs to outputs in either mode.
- Reset:
  - wp = rp = count = 0; outData = 0; outValid = 0.
  - outFull = 0, outEmpty = 1, outAlmostFull = 0, outAlmostEmpty = 1.
  - Both error flags = 0.
  - Reset mid-operation discards all contents; memory contents themselves need not be cleared.
  - inReset overrides every other input in the same cycle.

## Timing
- Write at edge N: outCount, outEmpty, outFull and the almost flags reflect it after edge N.
- FWFT: a write to an empty FIFO at edge N gives outValid = 1 with that data from edge N until the pop edge.
- Standard: read accepted at edge N gives outData/outValid after edge N, for one cycle.
- Sustained simultaneous read and write: throughput of 1 word/cycle, including at full and at empty+1.
- Flags update in the same cycle as the count; no extra pipeline stage.

## Test plan
- Fill/drain, FWFT=0, DEPTH=16, DATA_WIDTH=4:
  - Reset, then write 0x1..0xF,0x0 on 16 consecutive cycles.
  - Required: outFull=1 and outCount=16. outAlmostFull first asserts after the 14th write.
  - 16 reads return 0x1..0xF,0x0 in order, each with a 1-cycle outValid pulse; outEmpty=1 at the end.
- Overflow/underflow:
  - Write while full (no read) → outOverflow=1 and outCount stays 16.
  - Read while empty → outUnderflow=1.
  - inClearFlags for 1 cycle → both flags 0.
  - inClearFlags together with a new overflow → outOverflow stays 1.
- Full plus simultaneous read/write: at count=16 assert both for 4 cycles → count stays 16, no overflow, output order preserved.
- FWFT=1, DEPTH=5 (non-power-of-two wrap), DATA_WIDTH=1:
  - Write 1,0,1 → outValid=1 and outData=1 the cycle after the first write.
  - Pop three times → data 1,0,1.
  - Run 12 more write/read cycles, crossing wrap → no corruption, count correct.
- Reset mid-operation: with count=7, assert inReset for 1 cycle concurrently with a write and a read → all outputs at reset values, count=0; the next write is read back correctly.
